// File: rtl/rptr_empty_sync_if.sv
// Read-side handshake and status bundle for rptr_empty_sync.
// master drives the read request and the write-domain pointer; slave is the read controller.
interface rptr_empty_sync_if #(
    parameter int unsigned ADDRSIZE = 8
);
    logic                rinc;
    logic [ADDRSIZE:0]   wptr;
    logic                rclr_err;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE-1:0] raddr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;

    modport master (
        output rinc, wptr, rclr_err,
        input  rptr, raddr, rempty, raempty, rlevel, runderflow
    );

    modport slave (
        input  rinc, wptr, rclr_err,
        output rptr, raddr, rempty, raempty, rlevel, runderflow
    );
endinterface

// File: rtl/rptr_empty_sync.sv
// Async-FIFO read-pointer / empty-flag controller with write-pointer synchroniser.
// Define RPTR_EMPTY_SYNC_AEMPTY_EN to enable the AEMPTY_THRESH almost-empty comparator.
module rptr_empty_sync #(
    parameter int unsigned ADDRSIZE      = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input logic               rclk,
    input logic               rrst_n,
    rptr_empty_sync_if.slave  bus
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("rptr_empty_sync: SYNC_STAGES must be 2..4");
    end
    if (AEMPTY_THRESH > (1 << ADDRSIZE)) begin : g_bad_aempty_thresh
        $error("rptr_empty_sync: AEMPTY_THRESH must not exceed the FIFO depth");
    end

    logic [ADDRSIZE:0]   wq [SYNC_STAGES];
    logic [ADDRSIZE:0]   wq_gray;
    logic [ADDRSIZE:0]   wq_bin;
    logic [ADDRSIZE:0]   rbin;
    logic [ADDRSIZE:0]   rbnext;
    logic [ADDRSIZE:0]   rgnext;
    logic [ADDRSIZE:0]   rdiff;
    logic                rd_ok;
    logic                rd_err;
    logic [ADDRSIZE:0]   rptr_q;
    logic [ADDRSIZE-1:0] raddr_q;
    logic [ADDRSIZE:0]   rlevel_q;
    logic                rempty_q;
    logic                raempty_q;
    logic                runderflow_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                wq[i] <= '0;
            end
        end else begin
            wq[0] <= bus.wptr;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                wq[i] <= wq[i-1];
            end
        end
    end

    assign wq_gray = wq[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wq_bin = '0;
        for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
            wq_bin[i] = ^(wq_gray >> i);
        end
    end

    assign rd_ok  = bus.rinc & ~rempty_q;
    assign rd_err = bus.rinc & rempty_q;
    assign rbnext = rbin + (ADDRSIZE+1)'(rd_ok);
    assign rgnext = (rbnext >> 1) ^ rbnext;
    assign rdiff  = wq_bin - rbnext;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin     <= '0;
            rptr_q   <= '0;
            raddr_q  <= '0;
            rlevel_q <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin     <= rbnext;
            rptr_q   <= rgnext;
            raddr_q  <= rbnext[ADDRSIZE-1:0];
            rlevel_q <= rdiff;
            rempty_q <= (rgnext == wq_gray);
        end
    end

`ifdef RPTR_EMPTY_SYNC_AEMPTY_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            raempty_q <= 1'b1;
        end else begin
            raempty_q <= (rdiff <= (ADDRSIZE+1)'(AEMPTY_THRESH));
        end
    end
`else
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            raempty_q <= 1'b1;
        end else begin
            raempty_q <= (rgnext == wq_gray);
        end
    end
`endif

    // A new underflow wins over a clear in the same cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow_q <= 1'b0;
        end else if (rd_err) begin
            runderflow_q <= 1'b1;
        end else if (bus.rclr_err) begin
            runderflow_q <= 1'b0;
        end
    end

    assign bus.rptr       = rptr_q;
    assign bus.raddr      = raddr_q;
    assign bus.rlevel     = rlevel_q;
    assign bus.rempty     = rempty_q;
    assign bus.raempty    = raempty_q;
    assign bus.runderflow = runderflow_q;
endmodule

// File: tb/tb_rptr_empty_sync.sv
// Directed bench for rptr_empty_sync (ADDRSIZE=4, SYNC_STAGES=2, AEMPTY_THRESH=4).
module tb_rptr_empty_sync;
    localparam int unsigned AW = 4;

    logic rclk = 1'b0;
    logic rrst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [AW:0] wb = '0;
    logic [AW:0] rb = '0;
    logic [AW:0] prevg;

    rptr_empty_sync_if #(.ADDRSIZE(AW)) bus ();

    rptr_empty_sync #(
        .ADDRSIZE(AW),
        .SYNC_STAGES(2),
        .AEMPTY_THRESH(4)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .bus(bus.slave)
    );

    always #5 rclk = ~rclk;

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic exp_aempty(input int lvl);
`ifdef RPTR_EMPTY_SYNC_AEMPTY_EN
        return lvl <= 4;
`else
        return lvl == 0;
`endif
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            wb = wb + 1'b1;
            bus.wptr = gray(wb);
            step();
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        bus.rinc = 1'b1;
        bus.rclr_err = 1'b0;
        bus.wptr = '0;
        repeat (3) step();
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL reset_rempty: got %b want 1", bus.rempty); end
        tests++; if (bus.raempty !== 1'b1) begin fails++; $display("FAIL reset_raempty: got %b want 1", bus.raempty); end
        tests++; if (bus.rptr !== 5'd0) begin fails++; $display("FAIL reset_rptr: got %0d want 0", bus.rptr); end
        tests++; if (bus.raddr !== 4'd0) begin fails++; $display("FAIL reset_raddr: got %0d want 0", bus.raddr); end
        tests++; if (bus.rlevel !== 5'd0) begin fails++; $display("FAIL reset_rlevel: got %0d want 0", bus.rlevel); end
        tests++; if (bus.runderflow !== 1'b0) begin fails++; $display("FAIL reset_runderflow: got %b want 0", bus.runderflow); end
        bus.rinc = 1'b0;
        rrst_n = 1'b1;
        step();
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL release_rempty: got %b want 1", bus.rempty); end
    endtask

    task automatic test_write_visibility();
        wb = 5'd1; bus.wptr = gray(wb);
        step();
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL vis_edge1_rempty: got %b want 1", bus.rempty); end
        wb = 5'd2; bus.wptr = gray(wb);
        step();
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL vis_edge2_rempty: got %b want 1", bus.rempty); end
        step();
        tests++; if (bus.rempty !== 1'b0) begin fails++; $display("FAIL vis_edge3_rempty: got %b want 0", bus.rempty); end
        tests++; if (bus.rlevel !== 5'd1) begin fails++; $display("FAIL vis_edge3_rlevel: got %0d want 1", bus.rlevel); end
        step();
        tests++; if (bus.rlevel !== 5'd2) begin fails++; $display("FAIL vis_rlevel: got %0d want 2", bus.rlevel); end
        tests++; if (bus.raempty !== exp_aempty(2)) begin fails++; $display("FAIL vis_raempty: got %b want %b", bus.raempty, exp_aempty(2)); end
    endtask

    task automatic test_drain();
        bus.rinc = 1'b1;
        step();
        tests++; if (bus.raddr !== 4'd1) begin fails++; $display("FAIL drain1_raddr: got %0d want 1", bus.raddr); end
        tests++; if (bus.rempty !== 1'b0) begin fails++; $display("FAIL drain1_rempty: got %b want 0", bus.rempty); end
        tests++; if (bus.rlevel !== 5'd1) begin fails++; $display("FAIL drain1_rlevel: got %0d want 1", bus.rlevel); end
        step();
        tests++; if (bus.raddr !== 4'd2) begin fails++; $display("FAIL drain2_raddr: got %0d want 2", bus.raddr); end
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL drain2_rempty: got %b want 1", bus.rempty); end
        tests++; if (bus.runderflow !== 1'b0) begin fails++; $display("FAIL drain2_runderflow: got %b want 0", bus.runderflow); end
        step();
        tests++; if (bus.raddr !== 4'd2) begin fails++; $display("FAIL drain3_raddr: got %0d want 2", bus.raddr); end
        tests++; if (bus.rptr !== gray(5'd2)) begin fails++; $display("FAIL drain3_rptr: got %0d want %0d", bus.rptr, gray(5'd2)); end
        tests++; if (bus.runderflow !== 1'b1) begin fails++; $display("FAIL drain3_runderflow: got %b want 1", bus.runderflow); end
        rb = 5'd2;
    endtask

    task automatic test_err_clear();
        bus.rinc = 1'b1;
        bus.rclr_err = 1'b1;
        step();
        tests++; if (bus.runderflow !== 1'b1) begin fails++; $display("FAIL clr_with_set: got %b want 1", bus.runderflow); end
        bus.rinc = 1'b0;
        step();
        tests++; if (bus.runderflow !== 1'b0) begin fails++; $display("FAIL clr_alone: got %b want 0", bus.runderflow); end
        bus.rclr_err = 1'b0;
        step();
        tests++; if (bus.runderflow !== 1'b0) begin fails++; $display("FAIL clr_hold: got %b want 0", bus.runderflow); end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 5; c++) begin
            write_n(8);
            tests++; if (bus.rlevel !== 5'd8) begin fails++; $display("FAIL wrap_fill_rlevel c=%0d: got %0d want 8", c, bus.rlevel); end
            tests++; if (bus.rempty !== 1'b0) begin fails++; $display("FAIL wrap_fill_rempty c=%0d: got %b want 0", c, bus.rempty); end
            for (int i = 0; i < 8; i++) begin
                bus.rinc = 1'b1;
                prevg = gray(rb);
                step();
                rb = rb + 1'b1;
                tests++; if (bus.raddr !== rb[AW-1:0]) begin fails++; $display("FAIL wrap_raddr rb=%0d: got %0d want %0d", rb, bus.raddr, rb[AW-1:0]); end
                tests++; if (bus.rptr !== gray(rb)) begin fails++; $display("FAIL wrap_rptr rb=%0d: got %0d want %0d", rb, bus.rptr, gray(rb)); end
                tests++; if ($countones(bus.rptr ^ prevg) != 1) begin fails++; $display("FAIL wrap_gray_step rb=%0d: got %0d bits changed want 1", rb, $countones(bus.rptr ^ prevg)); end
                tests++; if (bus.rempty !== (i == 7)) begin fails++; $display("FAIL wrap_rempty rb=%0d: got %b want %b", rb, bus.rempty, (i == 7)); end
                tests++; if (bus.rlevel !== 5'(7 - i)) begin fails++; $display("FAIL wrap_rlevel rb=%0d: got %0d want %0d", rb, bus.rlevel, 7 - i); end
            end
            bus.rinc = 1'b0;
        end
    endtask

    task automatic test_aempty();
        write_n(6);
        tests++; if (bus.rlevel !== 5'd6) begin fails++; $display("FAIL ae_fill_rlevel: got %0d want 6", bus.rlevel); end
        tests++; if (bus.raempty !== exp_aempty(6)) begin fails++; $display("FAIL ae_fill_raempty: got %b want %b", bus.raempty, exp_aempty(6)); end
        for (int i = 0; i < 6; i++) begin
            bus.rinc = 1'b1;
            step();
            rb = rb + 1'b1;
            tests++; if (bus.rlevel !== 5'(5 - i)) begin fails++; $display("FAIL ae_rlevel lvl=%0d: got %0d", 5 - i, bus.rlevel); end
            tests++; if (bus.raempty !== exp_aempty(5 - i)) begin fails++; $display("FAIL ae_raempty lvl=%0d: got %b want %b", 5 - i, bus.raempty, exp_aempty(5 - i)); end
        end
        bus.rinc = 1'b0;
    endtask

    task automatic test_mid_reset();
        write_n(3);
        bus.rinc = 1'b1;
        step();
        bus.rinc = 1'b0;
        rrst_n = 1'b0;
        #1;
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL midrst_rempty: got %b want 1", bus.rempty); end
        tests++; if (bus.rptr !== 5'd0) begin fails++; $display("FAIL midrst_rptr: got %0d want 0", bus.rptr); end
        tests++; if (bus.raddr !== 4'd0) begin fails++; $display("FAIL midrst_raddr: got %0d want 0", bus.raddr); end
        tests++; if (bus.rlevel !== 5'd0) begin fails++; $display("FAIL midrst_rlevel: got %0d want 0", bus.rlevel); end
        tests++; if (bus.raempty !== 1'b1) begin fails++; $display("FAIL midrst_raempty: got %b want 1", bus.raempty); end
        wb = '0; rb = '0;
        bus.wptr = '0;
        bus.rinc = 1'b1;
        repeat (2) step();
        tests++; if (bus.rptr !== 5'd0) begin fails++; $display("FAIL midrst_hold_rptr: got %0d want 0", bus.rptr); end
        bus.rinc = 1'b0;
        rrst_n = 1'b1;
        step();
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL midrst_release_rempty: got %b want 1", bus.rempty); end
        tests++; if (bus.rlevel !== 5'd0) begin fails++; $display("FAIL midrst_release_rlevel: got %0d want 0", bus.rlevel); end
    endtask

    initial begin
        test_reset();
        test_write_visibility();
        test_drain();
        test_err_clear();
        test_wrap();
        test_aempty();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
